// File: rtl/camo_key_pkg.sv
// Shared types and helpers for the camouflage key loader: FSM state
// encoding, the default key width and the frame parity function.
package camo_key_pkg;

  localparam int KEY_W_DEF = 2;
  localparam int PAR_MAX_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_CHECK  = 2'd3
  } state_e;

  // Even parity: a frame is consistent when its parity bit equals XOR of the key bits.
  function automatic logic key_parity(input logic [PAR_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/camo_key_loader_if.sv
// Serial key-frame handshake between a key source (master) and the loader (slave).
interface camo_key_loader_if;

  logic load_start;
  logic sdi;
  logic sdi_valid;
  logic sdi_ready;

  modport master (
    output load_start,
    output sdi,
    output sdi_valid,
    input  sdi_ready
  );

  modport slave (
    input  load_start,
    input  sdi,
    input  sdi_valid,
    output sdi_ready
  );

endinterface

// File: rtl/camo_key_loader.sv
// Loads a parity-protected camouflage key serially and commits it to the
// dummy-wire select lines only when the frame is consistent and permitted.
module camo_key_loader
  import camo_key_pkg::*;
#(
  parameter int                   KEY_W       = KEY_W_DEF,
  parameter logic [2**KEY_W-1:0]  ALLOW_MASK  = '1,
  parameter logic [KEY_W-1:0]     DEFAULT_KEY = '0
) (
  input  logic               clk,
  input  logic               rst,
  camo_key_loader_if.slave   bus,
  output logic [KEY_W-1:0]   key_out,
  output logic               key_valid,
  output logic               err,
  output logic               busy
);

  localparam int CNT_W = (KEY_W > 1) ? $clog2(KEY_W) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(KEY_W - 1);

  state_e             state_r;
  logic [CNT_W-1:0]   count_r;
  logic [KEY_W-1:0]   shadow_r;
  logic               par_r;
  logic               pend_r;
  logic               ok_r;
  logic [KEY_W-1:0]   key_r;
  logic               key_valid_r;
  logic               err_r;
  logic               busy_r;
  logic               ready_r;
  logic               xfer_s;

  assign xfer_s        = bus.sdi_valid & ready_r;
  assign bus.sdi_ready = ready_r;
  assign key_out       = key_r;
  assign key_valid     = key_valid_r;
  assign err           = err_r;
  assign busy          = busy_r;

  // Frame FSM; the CHECK verdict is applied one edge later so key_out only moves after CHECK.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      count_r     <= '0;
      shadow_r    <= '0;
      par_r       <= 1'b0;
      pend_r      <= 1'b0;
      ok_r        <= 1'b0;
      key_r       <= DEFAULT_KEY;
      key_valid_r <= 1'b0;
      err_r       <= 1'b0;
      busy_r      <= 1'b0;
      ready_r     <= 1'b0;
    end else begin
      if (pend_r) begin
        pend_r <= 1'b0;
        if (ok_r) begin
          key_r       <= shadow_r;
          key_valid_r <= 1'b1;
          err_r       <= 1'b0;
        end else begin
          err_r <= 1'b1;
        end
      end

      case (state_r)
        ST_IDLE: begin
          if (bus.load_start) begin
            state_r  <= ST_SHIFT;
            shadow_r <= '0;
            count_r  <= '0;
            ready_r  <= 1'b1;
            busy_r   <= 1'b1;
          end else begin
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
          end
        end
        ST_SHIFT: begin
          ready_r <= 1'b1;
          busy_r  <= 1'b1;
          if (bus.load_start) begin
            shadow_r <= '0;
            count_r  <= '0;
          end else if (xfer_s) begin
            shadow_r[count_r] <= bus.sdi;
            if (count_r == LAST_IDX) begin
              state_r <= ST_PARITY;
            end else begin
              count_r <= count_r + CNT_W'(1);
            end
          end
        end
        ST_PARITY: begin
          busy_r <= 1'b1;
          if (bus.load_start) begin
            state_r  <= ST_SHIFT;
            shadow_r <= '0;
            count_r  <= '0;
            ready_r  <= 1'b1;
          end else if (xfer_s) begin
            par_r   <= bus.sdi;
            state_r <= ST_CHECK;
            ready_r <= 1'b0;
          end else begin
            ready_r <= 1'b1;
          end
        end
        ST_CHECK: begin
          pend_r  <= 1'b1;
          ok_r    <= (par_r == key_parity(PAR_MAX_W'(shadow_r))) && ALLOW_MASK[shadow_r];
          state_r <= ST_IDLE;
          ready_r <= 1'b0;
          busy_r  <= 1'b1;
        end
        default: begin
          state_r <= ST_IDLE;
          ready_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/camo_key_loader.md
CAMO_KEY_LOADER -- requirements
Module: camo_key_loader

Interface
REQ-001 Parameter KEY_W, default 2, width of the camouflage key. Each key bit drives one dummy-wire select input (D_0, D_1, ...).
REQ-002 Parameter ALLOW_MASK, default all-ones, width 2**KEY_W. Bit k=1 means key value k is a permitted mux setting.
REQ-003 Parameter DEFAULT_KEY, default 0, width KEY_W. This is the key driven after reset and before any successful commit.
REQ-004 clk  in  1  the single clock; every state element is updated on its rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 load_start  in  1  starts a new key frame; in SHIFT or PARITY it aborts the current frame and restarts.
REQ-007 sdi  in  1  serial key data, LSB first, followed by one parity bit.
REQ-008 sdi_valid  in  1  sdi carries a bit this cycle.
REQ-009 sdi_ready  out  1  the loader accepts a bit this cycle; a bit transfers when sdi_valid and sdi_ready are both high.
REQ-010 key_out  out  KEY_W  committed key; bit i drives D_i of the camouflaged netlist.
REQ-011 key_valid  out  1  a key has been committed since reset.
REQ-012 err  out  1  sticky flag: the last completed frame was rejected.
REQ-013 busy  out  1  the FSM is not in IDLE.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, SHIFT, PARITY, CHECK.
REQ-015 IDLE SHALL hold sdi_ready=0; load_start=1 moves to SHIFT, clears the shadow register and sets bit count=0.
REQ-016 SHIFT SHALL hold sdi_ready=1; each transfer writes sdi into shadow[count] and increments count; the transfer with count=KEY_W-1 moves to PARITY.
REQ-017 PARITY SHALL hold sdi_ready=1; one transfer captures the parity bit and moves to CHECK.
REQ-018 CHECK SHALL hold sdi_ready=0 and last exactly one cycle, then return to IDLE.
REQ-019 In CHECK, the frame is accepted when parity bit == XOR(shadow) and ALLOW_MASK[shadow]==1; both conditions are required.
REQ-020 On an accepted frame, key_out<=shadow, key_valid<=1, err<=0.
REQ-021 On a rejected frame, key_out and key_valid SHALL be held and err<=1.
REQ-022 Latency: with the parity bit transferred at edge k, key_out/err SHALL change at edge k+2 and busy SHALL be low from edge k+2.
REQ-023 Cycles with sdi_valid=0 SHALL stall the frame indefinitely with no change to count or shadow.
REQ-024 load_start in SHIFT or PARITY SHALL restart the frame: any same-cycle sdi transfer is ignored, shadow and count are cleared, the state becomes SHIFT, and key_out/err are unchanged.
REQ-025 load_start in CHECK SHALL be ignored.
REQ-026 key_out SHALL never change except in the cycle following CHECK; it is glitch-free to the netlist.

Reset
REQ-027 On rst=1, the following SHALL take effect at the next edge, overriding all other inputs: state=IDLE, key_out=DEFAULT_KEY, key_valid=0, err=0, busy=0, sdi_ready=0, count=0, shadow=0.
REQ-028 Reset in mid-frame SHALL discard the partial frame.

Structure
REQ-029 The state enum, the KEY_W default and a parity function SHALL reside in package camo_key_pkg.
REQ-030 The block SHALL be a single module with no sub-module; the shift register is inline.

Verification (KEY_W=2)
REQ-031 Good frame: load_start, then sdi 0,1 and parity 1 -> key_out=2'b10, key_valid=1, err=0 two edges after the parity transfer.
REQ-032 Bad parity: load_start, then sdi 1,0 and parity 0 -> err=1, key_out holds its prior value, key_valid unchanged.
REQ-033 Disallowed key: ALLOW_MASK=4'b0111, send 1,1 with parity 0 -> err=1, key_out unchanged; then send 0,1 with parity 1 -> key_out=2'b10, err=0.
REQ-034 Stall and abort: insert 5 idle cycles between bits -> same result as REQ-031. A load_start after the first bit restarts the frame, and the next 0,1,1 commits 2'b10.
REQ-035 Reset mid-frame: rst asserted in PARITY -> key_out=DEFAULT_KEY, key_valid=0, busy=0, and the parity bit is not consumed.
